// File: rtl/tx_pkg.sv
// Shared types and constants for the ciphertext transmit path.
// Blocks are 128-bit AES ciphertext words, streamed out as 16 bytes.
package tx_pkg;

    localparam int BLOCK_W         = 128;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [BYTE_W-1:0]  byte_t;

    // Byte idx of a block in stream order; MSB-first counts down from the top byte.
    function automatic byte_t select_byte(input block_t blk,
                                          input logic [IDX_W-1:0] idx,
                                          input logic msb_first);
        logic [IDX_W-1:0] pos;
        pos = msb_first ? ~idx : idx;
        return blk[pos*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/cipher_block_fifo.sv
// Circular buffer of ciphertext blocks with a level counter.
// The head entry is exposed combinationally; callers never push when full or pop when empty.
module cipher_block_fifo
    import tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [BLOCK_W-1:0]       push_data,
    input  logic                     pop,
    output logic [BLOCK_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    block_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; the level counter alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cipher_byte_serializer.sv
// Captures AES ciphertext blocks into a small FIFO and streams them as bytes,
// throttling the encryption pipeline through enc_enable when the FIFO fills.
module cipher_byte_serializer
    import tx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [127:0]           blk_data,
    input  logic                   blk_valid,
    output logic                   enc_enable,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_last,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [IDX_W-1:0] byte_idx;
    logic             push;
    logic             pop;
    logic             handshake;
    logic             at_last;
    block_t           head;

    // Both flags derive only from the registered level, so enc_enable never loops back through blk_valid.
    assign enc_enable = (fifo_level != LVL_W'(DEPTH));
    assign byte_valid = (fifo_level != '0);
    assign at_last    = (byte_idx == IDX_W'(BYTES_PER_BLOCK - 1));
    assign handshake  = byte_valid && byte_ready;
    assign push       = blk_valid && enc_enable;
    assign pop        = handshake && at_last;

    cipher_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (blk_data),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level)
    );

    // Index wraps 15 -> 0 on the same handshake that pops the head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_idx <= '0;
        end else if (handshake) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    assign byte_data = byte_valid ? select_byte(head, byte_idx, MSB_FIRST) : '0;
    assign byte_last = byte_valid && at_last;

endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Randomized and directed bench for cipher_byte_serializer, checked against a block-queue model.
// Two instances (MSB-first and LSB-first) share all stimulus.
module tb_cipher_byte_serializer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         byte_ready;

    logic         enc_enable, enc_enable_l;
    logic [7:0]   byte_data, byte_data_l;
    logic         byte_valid, byte_valid_l;
    logic         byte_last, byte_last_l;
    logic [2:0]   fifo_level, fifo_level_l;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of whole blocks plus count of bytes already sent from the head.
    logic [127:0] m_q[$];
    int           m_sent;
    logic [7:0]   got[$];

    always #5 clk = ~clk;

    cipher_byte_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .resetn(resetn), .blk_data(blk_data), .blk_valid(blk_valid),
        .enc_enable(enc_enable), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .fifo_level(fifo_level)
    );

    cipher_byte_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .resetn(resetn), .blk_data(blk_data), .blk_valid(blk_valid),
        .enc_enable(enc_enable_l), .byte_data(byte_data_l), .byte_valid(byte_valid_l),
        .byte_ready(byte_ready), .byte_last(byte_last_l), .fifo_level(fifo_level_l)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] nth_byte(input logic [127:0] blk, input int k, input bit msb);
        return msb ? 8'(blk >> (8 * (15 - k))) : 8'(blk >> (8 * k));
    endfunction

    task automatic check_outputs();
        bit         has;
        logic [7:0] e_msb, e_lsb;
        has   = (m_q.size() != 0);
        e_msb = has ? nth_byte(m_q[0], m_sent, 1'b1) : 8'h00;
        e_lsb = has ? nth_byte(m_q[0], m_sent, 1'b0) : 8'h00;
        check("byte_valid", 128'(byte_valid), 128'(has));
        check("byte_data",  128'(byte_data),  128'(e_msb));
        check("byte_last",  128'(byte_last),  128'(has && m_sent == 15));
        check("fifo_level", 128'(fifo_level), 128'(m_q.size()));
        check("enc_enable", 128'(enc_enable), 128'(m_q.size() != DEPTH));
        check("lsb_byte_data",  128'(byte_data_l),  128'(e_lsb));
        check("lsb_fifo_level", 128'(fifo_level_l), 128'(m_q.size()));
    endtask

    // One clock: drive at the falling edge, check mid-low-phase, update model at the rising edge.
    task automatic step(input logic v, input logic [127:0] d, input logic r);
        bit do_push, do_pop, hs;
        blk_valid  = v;
        blk_data   = d;
        byte_ready = r;
        #1;
        check_outputs();
        hs      = (m_q.size() != 0) && r;
        do_pop  = hs && m_sent == 15;
        do_push = v && (m_q.size() != DEPTH);
        if (hs) got.push_back(byte_data);
        @(posedge clk);
        if (do_pop) begin
            void'(m_q.pop_front());
            m_sent = 0;
        end else if (hs) begin
            m_sent++;
        end
        if (do_push) m_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        m_q.delete();
        m_sent = 0;
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] pat;
        int           lvl_before;

        resetn     = 1'b1;
        blk_valid  = 1'b0;
        blk_data   = '0;
        byte_ready = 1'b0;
        m_sent     = 0;
        @(negedge clk);
        do_reset();

        // Single block, both byte orders, ready held high.
        blk = 128'h00112233445566778899AABBCCDDEEFF;
        got.delete();
        step(1'b1, blk, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1);
        check("single_count", 128'(got.size()), 128'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check("single_byte", 128'(got[i]), 128'(8'(i * 8'h11)));

        // Backpressure pattern 1,0,0,1 on a random block.
        blk = {$urandom, $urandom, $urandom, $urandom};
        got.delete();
        step(1'b1, blk, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
        check("bp_count", 128'(got.size()), 128'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check("bp_byte", 128'(got[i]), 128'(nth_byte(blk, i, 1'b1)));

        // Fill and throttle: valid held high with incrementing blocks, ready low.
        pat = 128'h0;
        for (int i = 0; i < 8; i++) begin
            pat = pat + 128'h0101_0101_0101_0101_0101_0101_0101_0101;
            step(1'b1, pat, 1'b0);
        end
        check("fill_level", 128'(fifo_level), 128'd4);
        check("fill_enable", 128'(enc_enable), 128'd0);
        got.delete();
        for (int i = 0; i < 16 * 4; i++) step(1'b1, pat, 1'b1);
        check("drain_count", 128'(got.size()), 128'd64);
        for (int b = 0; b < 4; b++)
            check("drain_block", 128'(got[b * 16 + 15]),
                  128'(8'(b + 1)));
        for (int i = 0; i < 80; i++) step(1'b0, '0, 1'b1);

        // Simultaneous push and pop on the byte-15 handshake.
        step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
        lvl_before = int'(fifo_level);
        step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        check("pushpop_level", 128'(fifo_level), 128'(lvl_before));
        check("pushpop_nogap", 128'(byte_valid), 128'd1);
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1);

        // Reset in the middle of a block, then a fresh block from byte 0.
        step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        do_reset();
        got.delete();
        blk = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, blk, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);
        check("post_reset_count", 128'(got.size()), 128'd16);
        if (got.size() > 0) check("post_reset_first", 128'(got[0]), 128'(nth_byte(blk, 0, 1'b1)));

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) == 0), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 3) != 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
